// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing one L2 port among NUM_REQ L1 requesters: latches the winner's
// request toward L2, routes the response back to the winner only, and aborts stalled ops.
module l2_request_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int BLOCK_SIZE = 32,
    parameter int TIMEOUT    = 255,
    localparam int BLK_W     = DATA_WIDTH * (BLOCK_SIZE / (DATA_WIDTH / 8))
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            req_hit,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [NUM_REQ-1:0]            req_block_valid,
    output logic [BLK_W-1:0]              req_block_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]         l2_addr,
    output logic [DATA_WIDTH-1:0]         l2_wdata,
    output logic                          l2_read,
    output logic                          l2_write,
    input  logic [BLK_W-1:0]              l2_block_data,
    input  logic                          l2_block_valid,
    input  logic                          l2_hit,
    input  logic                          l2_ready
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       win_q;
    logic [WD_W-1:0]        wd_q;
    logic [NUM_REQ-1:0]     grant_q;
    logic [ADDR_WIDTH-1:0]  l2_addr_q;
    logic [DATA_WIDTH-1:0]  l2_wdata_q;
    logic                   l2_read_q;
    logic                   l2_write_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic [NUM_REQ-1:0]     req_hit_q;
    logic [NUM_REQ-1:0]     req_err_q;
    logic [NUM_REQ-1:0]     req_block_valid_q;
    logic [BLK_W-1:0]       req_block_data_q;

    logic [NUM_REQ-1:0]     pending;
    logic                   any_pending_d;
    logic [PTR_W-1:0]       win_d;
    logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

    assign pending = req_read | req_write;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        int cand;
        cand          = 0;
        any_pending_d = 1'b0;
        win_d         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!any_pending_d && pending[PTR_W'(cand)]) begin
                any_pending_d = 1'b1;
                win_d         = PTR_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            win_q             <= '0;
            wd_q              <= '0;
            grant_q           <= '0;
            l2_addr_q         <= '0;
            l2_wdata_q        <= '0;
            l2_read_q         <= 1'b0;
            l2_write_q        <= 1'b0;
            req_ready_q       <= '0;
            req_hit_q         <= '0;
            req_err_q         <= '0;
            req_block_valid_q <= '0;
            req_block_data_q  <= '0;
        end else begin
            req_ready_q       <= '0;
            req_hit_q         <= '0;
            req_err_q         <= '0;
            req_block_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_pending_d) begin
                        win_q      <= win_d;
                        grant_q    <= NUM_REQ'(1) << win_d;
                        l2_addr_q  <= addr_arr[win_d];
                        l2_wdata_q <= wdata_arr[win_d];
                        // A pending winner that is not reading must be writing; read wins if both.
                        l2_read_q  <= req_read[win_d];
                        l2_write_q <= ~req_read[win_d];
                        wd_q       <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    wd_q <= wd_q + 1'b1;
                    if (l2_ready) begin
                        l2_read_q          <= 1'b0;
                        l2_write_q         <= 1'b0;
                        grant_q            <= '0;
                        req_ready_q[win_q] <= 1'b1;
                        req_hit_q[win_q]   <= l2_hit;
                        if (l2_read_q && l2_block_valid) begin
                            req_block_data_q         <= l2_block_data;
                            req_block_valid_q[win_q] <= 1'b1;
                        end
                        state_q <= DRAIN;
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        l2_read_q          <= 1'b0;
                        l2_write_q         <= 1'b0;
                        grant_q            <= '0;
                        req_ready_q[win_q] <= 1'b1;
                        req_err_q[win_q]   <= 1'b1;
                        state_q            <= DRAIN;
                    end
                end
                DRAIN: begin
                    rr_ptr_q <= (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign req_hit         = req_hit_q;
    assign req_err         = req_err_q;
    assign req_block_valid = req_block_valid_q;
    assign req_block_data  = req_block_data_q;
    assign grant           = grant_q;
    assign l2_addr         = l2_addr_q;
    assign l2_wdata        = l2_wdata_q;
    assign l2_read         = l2_read_q;
    assign l2_write        = l2_write_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Randomized bench for l2_request_arbiter against a transaction-level round-robin model.
module tb_l2_request_arbiter;

    localparam int N     = 2;
    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int BS    = 32;
    localparam int TO    = 8;
    localparam int BLK_W = DW * (BS / (DW / 8));

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_hit;
    logic [N-1:0]      req_err;
    logic [N-1:0]      req_block_valid;
    logic [BLK_W-1:0]  req_block_data;
    logic [N-1:0]      grant;
    logic [AW-1:0]     l2_addr;
    logic [DW-1:0]     l2_wdata;
    logic              l2_read;
    logic              l2_write;
    logic [BLK_W-1:0]  l2_block_data;
    logic              l2_block_valid;
    logic              l2_hit;
    logic              l2_ready;

    int                n_chk;
    int                n_err;
    int                rr;
    logic [BLK_W-1:0]  model_blk;

    l2_request_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_hit(req_hit), .req_err(req_err),
        .req_block_valid(req_block_valid), .req_block_data(req_block_data),
        .grant(grant), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_block_data(l2_block_data), .l2_block_valid(l2_block_valid),
        .l2_hit(l2_hit), .l2_ready(l2_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < BLK_W / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    task automatic set_req(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read[i]            = r;
        req_write[i]           = w;
        req_addr[i*AW +: AW]   = a;
        req_wdata[i*DW +: DW]  = d;
    endtask

    // One full transaction: arbitration edge, L2 wait of lat cycles (0 = never), response, drain.
    task automatic run_txn(input int lat, input logic hit, input logic bv, input logic [BLK_W-1:0] blk);
        int            w;
        int            k;
        int            exp_k;
        bit            done;
        bit            succ;
        logic          rd_op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [N-1:0]  oh;
        w = -1;
        for (int j = 0; j < N; j++) begin
            int c;
            c = (rr + j) % N;
            if (w < 0 && (req_read[c] || req_write[c])) w = c;
        end
        if (w < 0) begin
            $display("FAIL stimulus: no pending requester, got none expected one");
            $fatal(1, "no pending requester");
        end
        rd_op = req_read[w];
        a     = req_addr[w*AW +: AW];
        d     = req_wdata[w*DW +: DW];
        oh    = N'(1) << w;
        tick();
        chk("grant", 256'(grant), 256'(oh));
        chk("l2_addr", 256'(l2_addr), 256'(a));
        chk("l2_wdata", 256'(l2_wdata), 256'(d));
        chk("l2_op", 256'({l2_read, l2_write}), 256'(rd_op ? 2'b10 : 2'b01));
        req_addr[w*AW +: AW]  = AW'($urandom);
        req_wdata[w*DW +: DW] = $urandom;
        k    = 0;
        done = 0;
        while (!done && k < 20) begin
            l2_ready       = (k + 1 == lat);
            l2_hit         = hit;
            l2_block_valid = bv;
            l2_block_data  = blk;
            tick();
            k++;
            l2_ready       = 1'b0;
            l2_hit         = 1'($urandom);
            l2_block_valid = 1'($urandom);
            l2_block_data  = rand_blk();
            if (req_ready != '0) done = 1;
            else chk("wait_hold", 256'({grant, l2_addr, l2_wdata, l2_read, l2_write}),
                     256'({oh, a, d, rd_op, ~rd_op}));
        end
        succ  = (lat >= 1 && lat <= TO);
        exp_k = succ ? lat : TO;
        chk("latency", 256'(k), 256'(exp_k));
        chk("req_ready", 256'(req_ready), 256'(oh));
        chk("req_err", 256'(req_err), 256'(succ ? '0 : oh));
        chk("req_hit", 256'(req_hit), 256'((succ && hit) ? oh : '0));
        if (succ && rd_op && bv) model_blk = blk;
        chk("blk_valid", 256'(req_block_valid), 256'((succ && rd_op && bv) ? oh : '0));
        chk("blk_data", 256'(req_block_data), 256'(model_blk));
        chk("drain", 256'({grant, l2_read, l2_write}), 256'(0));
        req_read[w]  = 1'b0;
        req_write[w] = 1'b0;
        if (!succ) begin
            l2_ready       = 1'b1;
            l2_hit         = 1'b1;
            l2_block_valid = 1'b1;
        end
        tick();
        l2_ready = 1'b0;
        chk("pulse_end", 256'({req_ready, req_hit, req_err, req_block_valid, grant, l2_read, l2_write}),
            256'(0));
        chk("blk_hold", 256'(req_block_data), 256'(model_blk));
        rr = (w + 1) % N;
    endtask

    task automatic ensure_all_pending();
        for (int i = 0; i < N; i++)
            if (!(req_read[i] || req_write[i])) set_req(i, 1'b1, 1'b0, AW'($urandom), $urandom);
    endtask

    initial begin
        logic [BLK_W-1:0] b;
        n_chk = 0;
        n_err = 0;
        rr = 0;
        model_blk = '0;
        rst_n = 1'b0;
        req_read = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        l2_ready = 1'b0;
        l2_hit = 1'b0;
        l2_block_valid = 1'b0;
        l2_block_data = '0;
        repeat (2) tick();
        chk("reset_out", 256'({req_ready, req_hit, req_err, req_block_valid, grant,
                               l2_addr, l2_wdata, l2_read, l2_write}), 256'(0));
        chk("reset_blk", 256'(req_block_data), 256'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_grant", 256'(grant), 256'(0));

        b = rand_blk();
        set_req(0, 1'b1, 1'b0, 11'h040, 32'h0);
        run_txn(3, 1'b1, 1'b1, b);

        set_req(1, 1'b0, 1'b1, 11'h3A4, 32'hDEADBEEF);
        run_txn(4, 1'b1, 1'b1, rand_blk());

        for (int t = 0; t < 4; t++) begin
            ensure_all_pending();
            run_txn(int'($urandom_range(1, 5)), 1'($urandom), 1'b1, rand_blk());
        end

        set_req(0, 1'b1, 1'b0, AW'($urandom), $urandom);
        run_txn(0, 1'b1, 1'b1, rand_blk());

        set_req(1, 1'b1, 1'b0, AW'($urandom), $urandom);
        run_txn(TO, 1'b1, 1'b1, rand_blk());
        set_req(0, 1'b1, 1'b0, AW'($urandom), $urandom);
        run_txn(1, 1'b0, 1'b1, rand_blk());

        set_req(1, 1'b1, 1'b1, AW'($urandom), $urandom);
        run_txn(2, 1'b1, 1'b1, rand_blk());

        set_req(0, 1'b1, 1'b0, AW'($urandom), $urandom);
        run_txn(2, 1'b1, 1'b1, rand_blk());
        set_req(1, 1'b1, 1'b0, 11'h155, $urandom);
        tick();
        chk("rst_pre_grant", 256'(grant), 256'(2'b10));
        tick();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_out", 256'({req_ready, req_hit, req_err, req_block_valid, grant,
                                   l2_addr, l2_wdata, l2_read, l2_write}), 256'(0));
        chk("rst_async_blk", 256'(req_block_data), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rr = 0;
        model_blk = '0;
        set_req(0, 1'b1, 1'b0, AW'($urandom), $urandom);
        run_txn(3, 1'b1, 1'b1, rand_blk());
        run_txn(2, 1'b0, 1'b1, rand_blk());

        for (int t = 0; t < 60; t++) begin
            int r;
            for (int i = 0; i < N; i++) begin
                if (!(req_read[i] || req_write[i]) && $urandom_range(0, 1) == 1) begin
                    r = int'($urandom_range(0, 2));
                    set_req(i, r != 1, r != 0, AW'($urandom), $urandom);
                end
            end
            if (req_read == '0 && req_write == '0)
                set_req(int'($urandom_range(0, N - 1)), 1'b1, 1'b0, AW'($urandom), $urandom);
            run_txn(int'($urandom_range(0, 9)), 1'($urandom), 1'($urandom), rand_blk());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
